// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative instruction cache with block refill
// One instruction per request: 1-cycle hits, per-set round-robin replacement on misses.
module icache_assoc #(
  parameter int offset_width = 2,
  parameter int line_width   = 6,
  parameter int way_width    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_instruction,
  input  logic        invalidate_all,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int tag_width  = 32 - offset_width - line_width - 2;
  localparam int block_size = 1 << offset_width;
  localparam int set_count  = 1 << line_width;
  localparam int ways       = 1 << way_width;
  localparam int ww         = (way_width > 0) ? way_width : 1;
  localparam logic [ww-1:0] last_way = ww'(ways - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_DATA, FILL, RESPOND} state_t;
  state_t state, next_state;

  logic [29:0]             addr_q;
  logic [offset_width-1:0] offset;
  logic [line_width-1:0]   index;
  logic [tag_width-1:0]    tag;
  logic [offset_width-1:0] beat_cnt;
  logic [ww-1:0]           victim_q, victim_sel, hit_way;
  logic                    hit, all_valid, accept, drop;
  logic [31:0]             last_instr;
  logic                    unused_addr_bits;

  logic                 valid_q  [set_count][ways];
  logic [ww-1:0]        rr_ptr   [set_count];
  logic [tag_width-1:0] tags     [set_count][ways];
  logic [31:0]          data     [set_count][ways][block_size];
  logic [31:0]          fill_buf [block_size];

  assign offset           = addr_q[offset_width-1:0];
  assign index            = addr_q[offset_width +: line_width];
  assign tag              = addr_q[29 -: tag_width];
  assign accept           = req_valid && req_ready;
  assign unused_addr_bits = ^req_addr[1:0];

  // Descending scan so the lowest matching / invalid way is the one kept.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    all_valid  = 1'b1;
    victim_sel = rr_ptr[index];
    for (int w = ways - 1; w >= 0; w--) begin
      if (valid_q[index][ww'(w)] && tags[index][ww'(w)] == tag) begin
        hit     = 1'b1;
        hit_way = ww'(w);
      end
      if (!valid_q[index][ww'(w)]) begin
        all_valid  = 1'b0;
        victim_sel = ww'(w);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = LOOKUP;
      LOOKUP:   if (!hit) next_state = MEM_REQ;
                else if (!accept) next_state = IDLE;
      MEM_REQ:  if (mem_req_ready) next_state = MEM_DATA;
      MEM_DATA: if (mem_resp_valid && beat_cnt == '1) next_state = FILL;
      FILL:     next_state = RESPOND;
      RESPOND:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = '0;
    resp_instruction = reset ? last_instr : '0;
    if (reset) begin
      case (state)
        IDLE:    req_ready = 1'b1;
        LOOKUP:  if (hit) begin
                   req_ready        = 1'b1;
                   resp_valid       = 1'b1;
                   resp_instruction = data[index][hit_way][offset];
                 end
        MEM_REQ: begin
                   mem_req_valid = 1'b1;
                   mem_req_addr  = {tag, index, {(offset_width + 2){1'b0}}};
                 end
        RESPOND: begin
                   resp_valid       = 1'b1;
                   resp_instruction = fill_buf[offset];
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      beat_cnt   <= '0;
      drop       <= 1'b0;
      victim_q   <= '0;
      last_instr <= '0;
      for (int s = 0; s < set_count; s++) begin
        rr_ptr[line_width'(s)] <= '0;
        for (int w = 0; w < ways; w++) valid_q[line_width'(s)][ww'(w)] <= 1'b0;
      end
    end else begin
      state <= next_state;
      if (accept) addr_q <= req_addr[31:2];
      if (resp_valid) last_instr <= resp_instruction;
      if (state == LOOKUP && !hit) begin
        victim_q <= victim_sel;
        if (all_valid) rr_ptr[index] <= (rr_ptr[index] == last_way) ? '0 : rr_ptr[index] + 1'b1;
      end
      if (state == MEM_REQ && mem_req_ready) beat_cnt <= '0;
      if (state == MEM_DATA && mem_resp_valid) beat_cnt <= beat_cnt + 1'b1;
      if (state == FILL) valid_q[index][victim_q] <= !drop;
      // Placed after the fill write so a coincident flush leaves the line invalid.
      if (invalidate_all)
        for (int s = 0; s < set_count; s++)
          for (int w = 0; w < ways; w++) valid_q[line_width'(s)][ww'(w)] <= 1'b0;
      if (next_state == IDLE) drop <= 1'b0;
      else if (invalidate_all && (state == MEM_REQ || state == MEM_DATA || state == FILL)) drop <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && state == MEM_DATA && mem_resp_valid) fill_buf[beat_cnt] <= mem_resp_data;
    if (reset && state == FILL) begin
      tags[index][victim_q] <= tag;
      for (int i = 0; i < block_size; i++)
        data[index][victim_q][offset_width'(i)] <= fill_buf[offset_width'(i)];
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc (2 ways, 4-word blocks, 64 sets)
module tb_icache_assoc;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid;
  logic [31:0] req_addr, resp_instruction;
  logic        invalidate_all;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;

  int errors = 0;
  int checks = 0;

  icache_assoc dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_instruction(resp_instruction),
    .invalidate_all(invalidate_all),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  // Reference: backing memory image plus per-set occupancy (which tags are resident).
  logic [31:0] mem_img [int unsigned];
  bit          m_valid [64][2];
  int unsigned m_tag   [64][2];
  int          m_rr    [64];

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_img.exists(wa)) return mem_img[wa];
    return (wa * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic void m_flush(input bit with_rr);
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      if (with_rr) m_rr[s] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Entered and left just after a falling edge with the cache idle.
  task automatic request(input logic [31:0] a, input int ready_dly, input int gap, input int inval_beat);
    int          s, vic, n;
    int unsigned t;
    bit          mhit;
    logic [31:0] blk, exp;
    s    = int'(a[9:4]);
    t    = 32'(a[31:10]);
    blk  = {a[31:4], 4'h0};
    exp  = rd(a);
    mhit = 0;
    vic  = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) mhit = 1;
    if (!mhit) begin
      for (int w = 0; w < 2; w++) if (vic < 0 && !m_valid[s][w]) vic = w;
      if (vic < 0) begin
        vic = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 2;
      end
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("lookup_hit", 32'(resp_valid), 32'(mhit));
    if (resp_valid === 1'b1) begin
      chk("hit_data", resp_instruction, exp);
      chk("hit_no_memreq", 32'(mem_req_valid), 32'd0);
      @(negedge clock);
      return;
    end
    @(negedge clock);
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_req_addr", mem_req_addr, blk);
    repeat (ready_dly) begin
      @(negedge clock);
      chk("mem_req_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("mem_req_hold_addr", mem_req_addr, blk);
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    chk("mem_req_dropped", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge clock);
      mem_resp_valid = 1'b1;
      mem_resp_data  = rd(blk + 32'(4 * i));
      invalidate_all = (i == inval_beat);
      @(negedge clock);
      mem_resp_valid = 1'b0;
      invalidate_all = 1'b0;
      mem_resp_data  = $urandom;
    end
    chk("fill_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clock);
    chk("miss_resp_valid", 32'(resp_valid), 32'd1);
    chk("miss_data", resp_instruction, exp);
    if (inval_beat >= 0) m_flush(0);
    else if (vic >= 0) begin
      m_valid[s][vic] = 1;
      m_tag[s][vic]   = t;
    end
    @(negedge clock);
    chk("resp_pulse_end", 32'(resp_valid), 32'd0);
    chk("resp_hold", resp_instruction, exp);
  endtask

  task automatic burst(input logic [31:0] base);
    chk("burst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = base;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("burst_resp_valid", 32'(resp_valid), 32'd1);
      chk("burst_data", resp_instruction, rd(base + 32'(4 * i)));
      chk("burst_ready_hold", 32'(req_ready), 32'd1);
      if (i < 3) req_addr = base + 32'(4 * (i + 1));
      else req_valid = 1'b0;
    end
    @(negedge clock);
    chk("burst_end", 32'(resp_valid), 32'd0);
  endtask

  function automatic logic [31:0] set5(input int t);
    return (32'(t) << 10) | (32'd5 << 4);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; invalidate_all = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    m_flush(1);
    for (int i = 0; i < 4; i++) mem_img[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_instr", resp_instruction, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    request(32'h1004, 0, 0, -1);
    request(32'h1004, 0, 0, -1);
    burst(32'h1000);

    for (int k = 0; k < 7; k++) request(set5((k == 4) ? 8 : (k == 5) ? 11 : (k == 6) ? 10 : 8 + k), 0, 0, -1);

    request(32'h3004, 0, 0, 2);
    request(32'h3004, 0, 0, -1);
    request(32'h1004, 0, 0, -1);

    // Reset in the middle of a refill, followed by stray beats.
    req_valid = 1'b1; req_addr = 32'h2008;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("mr_mem_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_0000 + 32'(i);
      @(negedge clock);
    end
    mem_resp_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("mr_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mr_rst_mem_req", 32'(mem_req_valid), 32'd0);
    chk("mr_rst_resp", 32'(resp_valid), 32'd0);
    chk("mr_rst_instr", resp_instruction, 32'd0);
    reset = 1'b1;
    m_flush(1);
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0000 + 32'(i);
      @(negedge clock);
      chk("stray_mem_req", 32'(mem_req_valid), 32'd0);
      chk("stray_resp", 32'(resp_valid), 32'd0);
      chk("stray_ready", 32'(req_ready), 32'd1);
    end
    mem_resp_valid = 1'b0;
    request(32'h2008, 0, 0, -1);
    request(32'h1004, 0, 0, -1);

    request(32'h4010, 5, 1, -1);
    request(32'h4018, 0, 0, -1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9) == 0) begin
        invalidate_all = 1'b1;
        @(negedge clock);
        invalidate_all = 1'b0;
        m_flush(0);
      end
      request((32'($urandom_range(3)) << 10) | (32'($urandom_range(2, 1)) << 4) | (32'($urandom_range(3)) << 2),
              int'($urandom_range(2)), int'($urandom_range(1)),
              ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
